// File: rtl/hram_bist_pkg.sv
// hram_bist_pkg: shared types and constants for the HyperRAM BIST sequencer.
// Holds the sequencer state encoding, pattern constants and the pattern step helpers.
// Optional build macro HRAM_BIST_LFSR_EN selects the LFSR pattern in hram_bist_pattern.
package hram_bist_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Feedback taps of the 16-bit Fibonacci LFSR: bits 15, 13, 12 and 10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] XOR_MASK     = 16'hA5A5;

    // One LFSR step: shift left, feedback parity enters at bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] p);
        return {p[14:0], ^(p & LFSR_TAPS)};
    endfunction

    // Address-derived pattern used when the LFSR is not built
    function automatic logic [15:0] addr_pattern(input logic [15:0] a);
        return a ^ XOR_MASK;
    endfunction

endpackage

// File: rtl/hram_bist_pattern.sv
// hram_bist_pattern: 16-bit test pattern source for the BIST sequencer.
// Output is the pattern that will be current after this clock edge (zero latency to the caller's register).
// HRAM_BIST_LFSR_EN defined: LFSR seeded by SEED; undefined: stateless {addr} ^ 16'hA5A5.
module hram_bist_pattern
    import hram_bist_pkg::*;
#(
    parameter int          ADDR_W = 12,
    parameter logic [15:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [15:0]       pattern_o
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

`ifdef HRAM_BIST_LFSR_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next LFSR value: reload on a new pass, step on each consumed word
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED_EFF;
        end else if (advance_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // LFSR state register
    always_ff @(posedge clk) begin
        if (!reset_) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // The caller registers this, so hand it the post-edge value
    assign pattern_o = lfsr_d;

    // The address does not feed the LFSR sequence
    logic unused_addr;
    assign unused_addr = ^addr_i;
`else
    // Caller supplies the post-edge address, so this is the post-edge pattern
    assign pattern_o = addr_pattern(16'(addr_i));

    // Sequencing inputs and the seed only matter for the LFSR build
    logic unused_ctl;
    assign unused_ctl = ^{clk, reset_, load_i, advance_i, SEED_EFF};
`endif

endmodule

// File: rtl/hram_bist.sv
// hram_bist: write a pattern over addresses 0..DEPTH-1, read it back, compare and report status.
// Latency: first request one cycle after start; one write per cycle; next read one cycle after each vld.
// Backpressure: request held stable until sram_ready; one read outstanding. Macro: HRAM_BIST_LFSR_EN.
module hram_bist
    import hram_bist_pkg::*;
#(
    parameter int          ADDR_W  = 12,
    parameter int          DATA_W  = 16,
    parameter int          DEPTH   = 4096,
    parameter logic [15:0] SEED    = DEFAULT_SEED,
    parameter int          TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              start,
    output logic              sram_req,
    output logic              sram_rd,
    input  logic              sram_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wr_data,
    input  logic              sram_rd_data_vld,
    input  logic [DATA_W-1:0] sram_rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // Wait counter spans 0..TIMEOUT-1; the abort fires on its last value
    localparam int                TO_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [7:0]        err_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              req_q;
    logic              rd_q;
    logic              busy_q;
    logic              done_q;
    logic              fail_q;

    logic              start_go;
    logic              at_last;
    logic              wr_acc;
    logic              rd_got;
    logic              timed_out;
    logic              spurious;
    logic              mismatch;
    logic              err_evt;
    logic              pat_load;
    logic              pat_adv;
    logic [15:0]       pat_nxt;

    // Event decode shared by the address counter, pattern source and FSM
    always_comb begin
        start_go  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        at_last   = (addr_q == LAST_ADDR);
        wr_acc    = (state_q == ST_WR) && req_q && sram_ready;
        rd_got    = (state_q == ST_RD_WAIT) && sram_rd_data_vld;
        timed_out = (state_q == ST_RD_WAIT) && !sram_rd_data_vld && (to_cnt_q == TO_LAST);
        spurious  = (state_q != ST_RD_WAIT) && sram_rd_data_vld;
        // wr_data_q holds the pattern of the current address, i.e. the expected read value
        mismatch  = rd_got && (sram_rd_data != wr_data_q);
        err_evt   = mismatch || timed_out || spurious;
        // Reseed at the start of each pass; step only on a consumed word
        pat_load  = start_go || (wr_acc && at_last);
        pat_adv   = (wr_acc || rd_got) && !at_last;
        addr_d    = addr_q;
        if (pat_load) begin
            addr_d = '0;
        end else if (pat_adv) begin
            addr_d = addr_q + 1'b1;
        end
    end

    hram_bist_pattern #(
        .ADDR_W (ADDR_W),
        .SEED   (SEED)
    ) u_pattern (
        .clk       (clk),
        .reset_    (reset_),
        .load_i    (pat_load),
        .advance_i (pat_adv),
        .addr_i    (addr_d),
        .pattern_o (pat_nxt)
    );

    // Sequencer FSM with registered request and status outputs
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wr_data_q   <= '0;
            fail_addr_q <= '0;
            err_cnt_q   <= '0;
            to_cnt_q    <= '0;
            req_q       <= 1'b0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            addr_q <= addr_d;
            if (pat_load || pat_adv) begin
                wr_data_q <= DATA_W'(pat_nxt);
            end

            // Error bookkeeping; a start in the same cycle overrides it below
            if (err_evt) begin
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
                if (!fail_q) begin
                    fail_q      <= 1'b1;
                    fail_addr_q <= addr_q;
                end
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_WR;
                        req_q       <= 1'b1;
                        rd_q        <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        err_cnt_q   <= '0;
                        fail_addr_q <= '0;
                    end
                end
                ST_WR: begin
                    // Request stays up; the last write turns straight into the first read
                    if (sram_ready && at_last) begin
                        state_q <= ST_RD_REQ;
                        rd_q    <= 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    if (sram_ready) begin
                        state_q  <= ST_RD_WAIT;
                        req_q    <= 1'b0;
                        to_cnt_q <= '0;
                    end
                end
                ST_RD_WAIT: begin
                    if (sram_rd_data_vld) begin
                        if (at_last) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            rd_q    <= 1'b0;
                        end else begin
                            state_q <= ST_RD_REQ;
                            req_q   <= 1'b1;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        // Controller never answered: abort the run
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        rd_q    <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    rd_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sram_req     = req_q;
    assign sram_rd      = rd_q;
    assign sram_addr    = addr_q;
    assign sram_wr_data = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    // Derived from registers so a late spurious error also clears it
    assign pass         = done_q && (err_cnt_q == 8'd0);
    assign fail         = fail_q;
    assign err_cnt      = err_cnt_q;
    assign fail_addr    = fail_addr_q;

endmodule
